// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS-subset controller: Moore FSM with a memory-wait watchdog.
// Optional `MCPU_BNE_EN adds bne decoding and the Branch_ne qualifier.
module mcpu_ctrl #(
    parameter int ALUC_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        OPcode,
    input  logic [5:0]        Fun,
    input  logic              MIO_ready,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              IorD,
    output logic              MemRead,
    output logic              mem_w,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              ALUSrc_A,
    output logic [1:0]        ALUSrc_B,
    output logic [1:0]        PCSource,
    output logic [ALUC_W-1:0] ALU_Control,
    output logic              CPU_MIO,
    output logic              Branch_ne,
    output logic              illegal,
    output logic              bus_err,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_WBM = 4'd4,
        S_MW  = 4'd5,
        S_EXR = 4'd6,
        S_WBR = 4'd7,
        S_BR  = 4'd8,
        S_JMP = 4'd9,
        S_EXI = 4'd10,
        S_WBI = 4'd11,
        S_ERR = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwcond;
        logic       iord;
        logic       memread;
        logic       memw;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
        logic       cpu_mio;
        logic       bne;
        logic       bus_err;
        logic       in_if;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic       WD_EN    = (TIMEOUT != 0);
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_state;
    ctl_t       r_ctl;
    logic [7:0] r_wdog;
    logic       w_fun_ok;
    logic [2:0] w_fun_alu;
    logic       w_dec_illegal;
    logic       w_bne_op;
    logic       w_wait;
    logic       w_wd_trip;
    logic       w_wd_entry;

`ifdef MCPU_BNE_EN
    assign w_bne_op = (OPcode == OP_BNE);
`else
    assign w_bne_op = 1'b0;
`endif

    always_comb begin
        w_fun_ok  = 1'b1;
        w_fun_alu = '0;
        case (Fun)
            6'b100000: w_fun_alu = 3'b010;
            6'b100010: w_fun_alu = 3'b110;
            6'b100100: w_fun_alu = 3'b000;
            6'b100101: w_fun_alu = 3'b001;
            6'b101010: w_fun_alu = 3'b111;
            6'b100111: w_fun_alu = 3'b100;
            6'b000010: w_fun_alu = 3'b101;
            6'b010110: w_fun_alu = 3'b011;
            default:   w_fun_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_dec_state   = S_IF;
        w_dec_illegal = 1'b0;
        case (OPcode)
            OP_LW, OP_SW:      w_dec_state = S_MA;
            OP_RTYPE: begin
                if (w_fun_ok) w_dec_state   = S_EXR;
                else          w_dec_illegal = 1'b1;
            end
            OP_BEQ:            w_dec_state = S_BR;
            OP_J:              w_dec_state = S_JMP;
            OP_ADDI, OP_SLTI:  w_dec_state = S_EXI;
            default: begin
                if (w_bne_op) w_dec_state   = S_BR;
                else          w_dec_illegal = 1'b1;
            end
        endcase
    end

    assign w_wait    = (r_state == S_IF) || (r_state == S_MR) || (r_state == S_MW);
    // MIO_ready in the trip cycle takes priority: the trip only matters when not ready.
    assign w_wd_trip = WD_EN && !MIO_ready && (r_wdog == WD_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF: begin
                if (MIO_ready)      w_next = S_ID;
                else if (w_wd_trip) w_next = S_ERR;
            end
            S_ID:  w_next = w_dec_state;
            S_MA:  w_next = (OPcode == OP_LW) ? S_MR : S_MW;
            S_MR: begin
                if (MIO_ready)      w_next = S_WBM;
                else if (w_wd_trip) w_next = S_ERR;
            end
            S_MW: begin
                if (MIO_ready)      w_next = S_IF;
                else if (w_wd_trip) w_next = S_ERR;
            end
            S_EXR: w_next = S_WBR;
            S_EXI: w_next = S_WBI;
            S_WBM, S_WBR, S_WBI, S_BR, S_JMP: w_next = S_IF;
            S_ERR: w_next = S_ERR;
            default: w_next = S_IF;
        endcase
    end

    assign w_wd_entry = (w_next != r_state) &&
                        ((w_next == S_IF) || (w_next == S_MR) || (w_next == S_MW));

    // Controls for the state about to be entered, so outputs come straight from flops.
    function automatic ctl_t ctl_for(input state_t s, input logic [5:0] op,
                                     input logic [2:0] fun_alu, input logic bne_op);
        ctl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.memread = 1'b1;
                c.cpu_mio = 1'b1;
                c.asb     = 2'b01;
                c.alu     = ALU_ADD;
                c.in_if   = 1'b1;
            end
            S_ID: begin
                c.asb = 2'b11;
                c.alu = ALU_ADD;
            end
            S_MA: begin
                c.asa = 1'b1;
                c.asb = 2'b10;
                c.alu = ALU_ADD;
            end
            S_MR: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
                c.cpu_mio = 1'b1;
            end
            S_WBM: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MW: begin
                c.memw    = 1'b1;
                c.iord    = 1'b1;
                c.cpu_mio = 1'b1;
            end
            S_EXR: begin
                c.asa = 1'b1;
                c.alu = fun_alu;
            end
            S_WBR: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BR: begin
                c.asa     = 1'b1;
                c.alu     = ALU_SUB;
                c.pcwcond = 1'b1;
                c.pcsrc   = 2'b01;
                c.bne     = bne_op;
            end
            S_JMP: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
            S_EXI: begin
                c.asa = 1'b1;
                c.asb = 2'b10;
                c.alu = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_WBI:   c.regwrite = 1'b1;
            S_ERR:   c.bus_err  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_ctl   <= ctl_for(S_IF, OPcode, w_fun_alu, w_bne_op);
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_for(w_next, OPcode, w_fun_alu, w_bne_op);
            if (w_wd_entry)
                r_wdog <= '0;
            else if (w_wait && !MIO_ready)
                r_wdog <= r_wdog + 8'd1;
        end
    end

    // Write enables are gated by rst so a reset edge never commits an access.
    assign PCWrite     = (r_ctl.pcwrite | (r_ctl.in_if & MIO_ready)) & ~rst;
    assign IRWrite     = r_ctl.in_if & MIO_ready & ~rst;
    assign PCWriteCond = r_ctl.pcwcond & ~rst;
    assign RegWrite    = r_ctl.regwrite & ~rst;
    assign mem_w       = r_ctl.memw & ~rst;
    assign IorD        = r_ctl.iord;
    assign MemRead     = r_ctl.memread;
    assign RegDst      = r_ctl.regdst;
    assign MemtoReg    = r_ctl.memtoreg;
    assign ALUSrc_A    = r_ctl.asa;
    assign ALUSrc_B    = r_ctl.asb;
    assign PCSource    = r_ctl.pcsrc;
    assign CPU_MIO     = r_ctl.cpu_mio;
    assign Branch_ne   = r_ctl.bne;
    assign bus_err     = r_ctl.bus_err;
    assign illegal     = (r_state == S_ID) & w_dec_illegal;
    assign state       = r_state;

    always_comb begin
        ALU_Control      = '0;
        ALU_Control[2:0] = r_ctl.alu;
    end

endmodule

// File: doc/mcpu_ctrl.md
MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 Parameter ALUC_W, default 3: ALU_Control width; codes occupy bits [2:0], upper bits SHALL be 0.
REQ-002 Parameter TIMEOUT, default 16, range 0..255: maximum MIO_ready wait in cycles; 0 disables the watchdog.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- OPcode  in  6  instruction [31:26], taken from the datapath IR.
- Fun  in  6  instruction [5:0].
- MIO_ready  in  1  memory/IO access complete this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrc_A  out  1 each  datapath controls.
- ALUSrc_B  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALU_Control  out  ALUC_W  ALU operation code.
- CPU_MIO  out  1  CPU owns the memory bus.
- Branch_ne  out  1  branch on not-equal qualifier.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- bus_err  out  1  sticky watchdog error.
- state  out  4  current FSM state, for debug.

Function
REQ-004 Moore FSM; outputs depend only on state, plus MIO_ready in IF. Signals not listed for a state SHALL be 0. Add is ALU 010.
REQ-005 IF(0): MemRead, CPU_MIO, ALUSrc_B=01, add; PCWrite=IRWrite=MIO_ready; stay while !MIO_ready, else go to ID.
REQ-006 ID(1): ALUSrc_B=11, add. Decode:
- lw 100011 / sw 101011 -> MA.
- R-type 000000 with known Fun -> EX_R.
- beq 000100 -> BR.
- j 000010 -> JMP.
- addi 001000 / slti 001010 -> EX_I.
- anything else -> IF, with illegal=1 for that cycle.
REQ-007 MA(2): ALUSrc_A=1, ALUSrc_B=10, add; lw -> MR, sw -> MW.
REQ-008 MR(3): MemRead, IorD, CPU_MIO; wait for MIO_ready, then WB_M. WB_M(4): MemtoReg, RegWrite, RegDst=0 -> IF.
REQ-009 MW(5): mem_w, IorD, CPU_MIO; wait for MIO_ready, then IF.
REQ-010 EX_R(6): ALUSrc_A=1, ALUSrc_B=00, then WB_R. Fun map: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, 100111->100, 000010->101, 010110->011; other Fun values are illegal in ID. WB_R(7): RegDst=1, RegWrite -> IF.
REQ-011 BR(8): ALUSrc_A=1, ALUSrc_B=00, ALU 110, PCWriteCond, PCSource=01 -> IF.
REQ-012 JMP(9): PCWrite, PCSource=10 -> IF.
REQ-013 EX_I(10): ALUSrc_A=1, ALUSrc_B=10, ALU 010 (addi) or 111 (slti) -> WB_I. WB_I(11): RegDst=0, RegWrite -> IF.
REQ-014 Watchdog, 8-bit counter:
- cleared on entry to IF, MR or MW.
- increments each wait-state cycle with MIO_ready=0.
- if TIMEOUT!=0 and the count reaches TIMEOUT-1 while MIO_ready=0 -> ERR(12).
- MIO_ready=1 in that same cycle wins: normal transition, no error.
REQ-015 ERR(12): bus_err=1 and all write enables 0; held until rst.
REQ-016 Encodings 13..15 are unreachable and SHALL go to IF on the next clock.

Reset
REQ-017 rst sampled high at a clock edge: state=IF, counter=0, bus_err=0.
REQ-018 While rst=1: PCWrite, PCWriteCond, IRWrite, RegWrite and mem_w forced to 0, regardless of MIO_ready.
REQ-019 Reset during MR, MW or ERR abandons the access; no write enable is asserted on that edge.

Configuration
REQ-020 Macro MCPU_BNE_EN defined: bne 000101 -> BR with Branch_ne=1 during BR, so the datapath branches on ALU nonzero.
REQ-021 Macro undefined: Branch_ne is tied 0 and 000101 is illegal (REQ-006).

Verification
REQ-022 lw, MIO_ready always 1 -> states 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4.
REQ-023 add (Fun 100000), MIO_ready low for 3 cycles in IF -> IF held 4 cycles, PCWrite=IRWrite=0 for the first 3 and 1 on the 4th; ALU_Control=010 in EX_R.
REQ-024 TIMEOUT=4, sw with MIO_ready stuck 0 in MW -> ERR after 4 MW cycles, bus_err=1; after rst=1 -> IF, bus_err=0.
REQ-025 OPcode 111111, then R-type with Fun 000000 -> each gives illegal=1 for one cycle in ID, then IF; no write enable asserted.
REQ-026 bne 000101, with and without MCPU_BNE_EN -> BR with Branch_ne=1 and PCWriteCond=1, versus illegal pulse and return to IF.
REQ-027 rst=1 for one cycle while in MR -> state=0 next cycle and RegWrite never asserted.
